// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the memory-side bridge.
// slave = arbiter view, master = cache/memory environment view.
interface cache_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 128
);
   // instruction cache refill channel
   logic              i_rd_req;
   logic [2:0]        i_rd_type;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              i_rd_rdy;
   logic              i_ret_valid;
   logic              i_ret_last;
   logic [DATA_W-1:0] i_ret_data;

   // data cache refill channel
   logic              d_rd_req;
   logic [2:0]        d_rd_type;
   logic [ADDR_W-1:0] d_rd_addr;
   logic              d_rd_rdy;
   logic              d_ret_valid;
   logic              d_ret_last;
   logic [DATA_W-1:0] d_ret_data;

   // data cache write-back channel
   logic              d_wr_req;
   logic [2:0]        d_wr_type;
   logic [ADDR_W-1:0] d_wr_addr;
   logic [3:0]        d_wr_wstrb;
   logic [LINE_W-1:0] d_wr_data;
   logic              d_wr_rdy;

   // shared memory-side port
   logic              mem_rd_req;
   logic [2:0]        mem_rd_type;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_rdy;
   logic              mem_ret_valid;
   logic              mem_ret_last;
   logic [DATA_W-1:0] mem_ret_data;
   logic              mem_wr_req;
   logic [2:0]        mem_wr_type;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [3:0]        mem_wr_wstrb;
   logic [LINE_W-1:0] mem_wr_data;
   logic              mem_wr_rdy;

   modport slave (
      input  i_rd_req, i_rd_type, i_rd_addr,
      output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      input  d_rd_req, d_rd_type, d_rd_addr,
      output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      output d_wr_rdy,
      output mem_rd_req, mem_rd_type, mem_rd_addr,
      input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
      output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
      input  mem_wr_rdy
   );

   modport master (
      output i_rd_req, i_rd_type, i_rd_addr,
      input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      output d_rd_req, d_rd_type, d_rd_addr,
      input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      input  d_wr_rdy,
      input  mem_rd_req, mem_rd_type, mem_rd_addr,
      output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
      input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
      output mem_wr_rdy
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory read/write port between icache (i) and dcache (d): round-robin
// refill arbitration, single-entry write-back buffer with read-after-write line hazard.
// Define ARB_FIXED_PRIO_EN to make d win every contested arbitration instead.
module cache_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LINE_W   = 128,
   parameter int OFFSET_W = 4
) (
   input  logic clk,
   input  logic reset,
   cache_mem_arbiter_if.slave bus
);

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_WAIT = 1'b1;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   logic [0:0]        r_state;
   logic              owner;

   logic              wb_full;
   logic [2:0]        wb_type;
   logic [ADDR_W-1:0] wb_addr;
   logic [3:0]        wb_wstrb;
   logic [LINE_W-1:0] wb_data;

   logic hazard_i, hazard_d;
   logic elig_i, elig_d;
   logic sel;
   logic cand;
   logic rd_fire;
   logic beat_ok;
   logic last_beat;

   // A read of the line sitting in the write buffer must wait for it to drain.
   assign hazard_i = wb_full &&
                     (bus.i_rd_addr[ADDR_W-1:OFFSET_W] == wb_addr[ADDR_W-1:OFFSET_W]);
   assign hazard_d = wb_full &&
                     (bus.d_rd_addr[ADDR_W-1:OFFSET_W] == wb_addr[ADDR_W-1:OFFSET_W]);

   assign elig_i = bus.i_rd_req && !hazard_i;
   assign elig_d = bus.d_rd_req && !hazard_d;

`ifdef ARB_FIXED_PRIO_EN
   assign sel = elig_d;
`else
   logic last_grant;

   // Contested grant goes to the port that did not win last time.
   assign sel = (elig_i && elig_d) ? ~last_grant : elig_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_I;
      end else if (rd_fire) begin
         last_grant <= sel;
      end
   end
`endif

   assign cand      = (r_state == R_IDLE) && (elig_i || elig_d);
   assign rd_fire   = cand && bus.mem_rd_rdy;
   assign beat_ok   = (r_state == R_WAIT) && bus.mem_ret_valid;
   assign last_beat = beat_ok && bus.mem_ret_last;

   assign bus.mem_rd_req  = cand;
   assign bus.mem_rd_type = cand ? (sel ? bus.d_rd_type : bus.i_rd_type) : 3'b000;
   assign bus.mem_rd_addr = cand ? (sel ? bus.d_rd_addr : bus.i_rd_addr) : '0;

   assign bus.i_rd_rdy = cand && (sel == PORT_I) && bus.mem_rd_rdy;
   assign bus.d_rd_rdy = cand && (sel == PORT_D) && bus.mem_rd_rdy;

   // NOTE: returned beats pass straight through to the owner in the same cycle;
   // gating with the owner keeps the other cache's outputs quiet.
   assign bus.i_ret_valid = beat_ok && (owner == PORT_I);
   assign bus.i_ret_last  = bus.i_ret_valid && bus.mem_ret_last;
   assign bus.i_ret_data  = bus.i_ret_valid ? bus.mem_ret_data : '0;

   assign bus.d_ret_valid = beat_ok && (owner == PORT_D);
   assign bus.d_ret_last  = bus.d_ret_valid && bus.mem_ret_last;
   assign bus.d_ret_data  = bus.d_ret_valid ? bus.mem_ret_data : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= R_IDLE;
         owner   <= PORT_I;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (rd_fire) begin
                  r_state <= R_WAIT;
                  owner   <= sel;
               end
            end
            R_WAIT: begin
               if (last_beat) begin
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // NOTE: the buffered fields are reset as well so every memory-side output
   // reads zero during reset, not just the request flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_full  <= 1'b0;
         wb_type  <= '0;
         wb_addr  <= '0;
         wb_wstrb <= '0;
         wb_data  <= '0;
      end else if (wb_full) begin
         if (bus.mem_wr_rdy) begin
            wb_full <= 1'b0;
         end
      end else if (bus.d_wr_req) begin
         wb_full  <= 1'b1;
         wb_type  <= bus.d_wr_type;
         wb_addr  <= bus.d_wr_addr;
         wb_wstrb <= bus.d_wr_wstrb;
         wb_data  <= bus.d_wr_data;
      end
   end

   assign bus.d_wr_rdy     = !wb_full;
   assign bus.mem_wr_req   = wb_full;
   assign bus.mem_wr_type  = wb_type;
   assign bus.mem_wr_addr  = wb_addr;
   assign bus.mem_wr_wstrb = wb_wstrb;
   assign bus.mem_wr_data  = wb_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue-based model.
module tb_cache_mem_arbiter;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int LINE_W   = 128;
   localparam int OFFSET_W = 4;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) bus ();

   cache_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [2:0]   typ;
      logic [31:0]  addr;
      logic [3:0]   wstrb;
      logic [127:0] data;
   } wr_t;

   wr_t wbq[$];       // pending write-back, at most one
   bit  burst_q[$];   // owner (0=i, 1=d) of the read in flight, at most one
   bit  grants[$];    // history of granted ports
   bit  acc_i, acc_d, acc_w;

   function automatic bit blocked(logic [31:0] a);
      return (wbq.size() != 0) && (a[31:4] == wbq[0].addr[31:4]);
   endfunction

   function automatic bit winner(bit ei, bit ed);
      if (ei && ed) begin
         if (FIXED) return 1'b1;
         if (grants.size() == 0) return 1'b1;
         return !grants[grants.size()-1];
      end
      return ed;
   endfunction

   always @(negedge clk) begin
      bit ei, ed, w, req, exp_ir, exp_dr, own_i, own_d;
      if (reset) begin
         wbq.delete();
         burst_q.delete();
         grants.delete();
         acc_i = 1'b0;
         acc_d = 1'b0;
         acc_w = 1'b0;
      end else begin
         ei     = bus.i_rd_req && !blocked(bus.i_rd_addr);
         ed     = bus.d_rd_req && !blocked(bus.d_rd_addr);
         w      = winner(ei, ed);
         req    = (burst_q.size() == 0) && (ei || ed);
         exp_ir = req && !w && bus.mem_rd_rdy;
         exp_dr = req && w && bus.mem_rd_rdy;
         check("mem_rd_req", bus.mem_rd_req, req);
         check("i_rd_rdy", bus.i_rd_rdy, exp_ir);
         check("d_rd_rdy", bus.d_rd_rdy, exp_dr);
         if (req) begin
            check("mem_rd_addr", bus.mem_rd_addr, w ? bus.d_rd_addr : bus.i_rd_addr);
            check("mem_rd_type", bus.mem_rd_type, w ? bus.d_rd_type : bus.i_rd_type);
         end
         own_i = (burst_q.size() != 0) && (burst_q[0] == 1'b0) && bus.mem_ret_valid;
         own_d = (burst_q.size() != 0) && (burst_q[0] == 1'b1) && bus.mem_ret_valid;
         check("i_ret_valid", bus.i_ret_valid, own_i);
         check("i_ret_last", bus.i_ret_last, own_i && bus.mem_ret_last);
         check("d_ret_valid", bus.d_ret_valid, own_d);
         check("d_ret_last", bus.d_ret_last, own_d && bus.mem_ret_last);
         if (own_i) check("i_ret_data", bus.i_ret_data, bus.mem_ret_data);
         if (own_d) check("d_ret_data", bus.d_ret_data, bus.mem_ret_data);
         check("d_wr_rdy", bus.d_wr_rdy, wbq.size() == 0);
         check("mem_wr_req", bus.mem_wr_req, wbq.size() != 0);
         if (wbq.size() != 0) begin
            check("mem_wr_type", bus.mem_wr_type, wbq[0].typ);
            check("mem_wr_addr", bus.mem_wr_addr, wbq[0].addr);
            check("mem_wr_wstrb", bus.mem_wr_wstrb, wbq[0].wstrb);
            check("mem_wr_data", bus.mem_wr_data, wbq[0].data);
         end
         acc_i = exp_ir;
         acc_d = exp_dr;
         acc_w = bus.d_wr_req && (wbq.size() == 0);
         if (burst_q.size() != 0) begin
            if (bus.mem_ret_valid && bus.mem_ret_last) burst_q.delete();
         end else if (req && bus.mem_rd_rdy) begin
            burst_q.push_back(w);
            grants.push_back(w);
         end
         if (wbq.size() != 0) begin
            if (bus.mem_wr_rdy) wbq.delete();
         end else if (bus.d_wr_req) begin
            wbq.push_back('{typ: bus.d_wr_type, addr: bus.d_wr_addr,
                            wstrb: bus.d_wr_wstrb, data: bus.d_wr_data});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
      bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
      bus.d_wr_req = 0; bus.d_wr_type = 0; bus.d_wr_addr = 0;
      bus.d_wr_wstrb = 0; bus.d_wr_data = 0;
      bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
      bus.mem_ret_data = 0; bus.mem_wr_rdy = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'h1000_0000;
      a[5:4] = 2'($urandom_range(0, 3));
      a[3:0] = 4'($urandom_range(0, 15));
      return a;
   endfunction

   initial begin
      bit exp_d;
      idle_inputs();
      reset = 1'b1;
      #1;
      check("rst_mem_rd_req", bus.mem_rd_req, 0);
      check("rst_i_rd_rdy", bus.i_rd_rdy, 0);
      check("rst_d_rd_rdy", bus.d_rd_rdy, 0);
      check("rst_mem_wr_req", bus.mem_wr_req, 0);
      check("rst_d_wr_rdy", bus.d_wr_rdy, 1);
      check("rst_i_ret_valid", bus.i_ret_valid, 0);
      tick(); tick();
      reset = 1'b0;

      // single icache refill, four beats
      tick();
      bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h1000_0040;
      bus.mem_rd_rdy = 1;
      #1;
      check("t1_mem_rd_req", bus.mem_rd_req, 1);
      check("t1_mem_rd_addr", bus.mem_rd_addr, 32'h1000_0040);
      check("t1_i_rd_rdy", bus.i_rd_rdy, 1);
      check("t1_d_rd_rdy", bus.d_rd_rdy, 0);
      tick();
      bus.i_rd_req = 0;
      #1;
      check("t1_i_rd_rdy_once", bus.i_rd_rdy, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         bus.mem_ret_valid = 1; bus.mem_ret_data = 32'hA0 + k; bus.mem_ret_last = (k == 3);
         #1;
         check("t1_i_ret_valid", bus.i_ret_valid, 1);
         check("t1_i_ret_data", bus.i_ret_data, 32'hA0 + k);
         check("t1_i_ret_last", bus.i_ret_last, k == 3);
         check("t1_d_ret_valid", bus.d_ret_valid, 0);
      end
      tick();
      bus.mem_ret_valid = 0; bus.mem_ret_last = 0;

      // both ports held: d, i, d (d, d, d with fixed priority)
      bus.i_rd_req = 1; bus.i_rd_addr = 32'h1000_0100;
      bus.d_rd_req = 1; bus.d_rd_addr = 32'h2000_0100;
      for (int g = 0; g < 3; g++) begin
         exp_d = FIXED ? 1'b1 : (g != 1);
         #1;
         check("t2_d_rd_rdy", bus.d_rd_rdy, exp_d);
         check("t2_i_rd_rdy", bus.i_rd_rdy, !exp_d);
         check("t2_mem_rd_addr", bus.mem_rd_addr, exp_d ? 32'h2000_0100 : 32'h1000_0100);
         tick();
         bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'h77 + g;
         #1;
         check("t2_d_ret_valid", bus.d_ret_valid, exp_d);
         check("t2_i_ret_valid", bus.i_ret_valid, !exp_d);
         check("t2_no_req_in_wait", bus.mem_rd_req, 0);
         tick();
         bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
         if (g == 2) begin
            bus.i_rd_req = 0;
            bus.d_rd_req = 0;
         end
      end

      // write buffer hazard
      bus.d_wr_req = 1; bus.d_wr_type = 3'b100; bus.d_wr_addr = 32'h2000_0000;
      bus.d_wr_wstrb = 4'hf; bus.d_wr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      bus.mem_wr_rdy = 0;
      #1;
      check("t3_d_wr_rdy_empty", bus.d_wr_rdy, 1);
      check("t3_mem_wr_req_empty", bus.mem_wr_req, 0);
      tick();
      bus.d_wr_req = 0;
      bus.d_rd_req = 1; bus.d_rd_type = 3'b100; bus.d_rd_addr = 32'h2000_0008;
      #1;
      check("t3_d_wr_rdy_full", bus.d_wr_rdy, 0);
      check("t3_mem_wr_req", bus.mem_wr_req, 1);
      check("t3_mem_wr_addr", bus.mem_wr_addr, 32'h2000_0000);
      check("t3_mem_wr_data", bus.mem_wr_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      check("t3_hazard_no_req", bus.mem_rd_req, 0);
      check("t3_hazard_d_rdy", bus.d_rd_rdy, 0);
      tick();
      bus.i_rd_req = 1; bus.i_rd_addr = 32'h3000_0000;
      #1;
      check("t3_i_mem_rd_req", bus.mem_rd_req, 1);
      check("t3_i_mem_rd_addr", bus.mem_rd_addr, 32'h3000_0000);
      check("t3_i_rd_rdy", bus.i_rd_rdy, 1);
      check("t3_d_rd_rdy_blocked", bus.d_rd_rdy, 0);
      tick();
      bus.i_rd_req = 0; bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hBEEF;
      #1;
      check("t3_i_ret_valid", bus.i_ret_valid, 1);
      check("t3_d_ret_valid", bus.d_ret_valid, 0);
      tick();
      bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_wr_rdy = 1;
      #1;
      check("t3_still_hazard", bus.mem_rd_req, 0);
      check("t3_drain_req", bus.mem_wr_req, 1);
      tick();
      bus.mem_wr_rdy = 0;
      #1;
      check("t3_drained_wr_rdy", bus.d_wr_rdy, 1);
      check("t3_drained_wr_req", bus.mem_wr_req, 0);
      check("t3_d_granted", bus.d_rd_rdy, 1);
      check("t3_d_mem_rd_addr", bus.mem_rd_addr, 32'h2000_0008);
      tick();
      bus.d_rd_req = 0; bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hCAFE;
      #1;
      check("t3_d_ret_valid", bus.d_ret_valid, 1);
      check("t3_d_ret_data", bus.d_ret_data, 32'hCAFE);
      tick();
      bus.mem_ret_valid = 0; bus.mem_ret_last = 0;

      // memory stalls acceptance for five cycles
      bus.mem_rd_rdy = 0; bus.d_rd_req = 1; bus.d_rd_addr = 32'h4000_0010;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t4_stall_req", bus.mem_rd_req, 1);
         check("t4_stall_addr", bus.mem_rd_addr, 32'h4000_0010);
         check("t4_stall_d_rdy", bus.d_rd_rdy, 0);
         tick();
      end
      bus.mem_rd_rdy = 1;
      #1;
      check("t4_accept", bus.d_rd_rdy, 1);
      tick();
      bus.d_rd_req = 0;
      #1;
      check("t4_in_wait", bus.mem_rd_req, 0);

      // reset in the middle of a four-beat burst
      for (int k = 0; k < 2; k++) begin
         tick();
         bus.mem_ret_valid = 1; bus.mem_ret_last = 0; bus.mem_ret_data = 32'hD0 + k;
         #1;
         check("t5_beat", bus.d_ret_valid, 1);
      end
      tick();
      reset = 1'b1; bus.mem_ret_data = 32'hD2;
      #1;
      check("t5_rst_d_ret_valid", bus.d_ret_valid, 0);
      check("t5_rst_d_ret_data", bus.d_ret_data, 0);
      check("t5_rst_i_ret_valid", bus.i_ret_valid, 0);
      check("t5_rst_mem_rd_req", bus.mem_rd_req, 0);
      check("t5_rst_mem_wr_req", bus.mem_wr_req, 0);
      check("t5_rst_mem_wr_addr", bus.mem_wr_addr, 0);
      check("t5_rst_mem_wr_data", bus.mem_wr_data, 0);
      tick();
      reset = 1'b0; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hD3;
      #1;
      check("t5_stray_d", bus.d_ret_valid, 0);
      check("t5_stray_i", bus.i_ret_valid, 0);
      tick();
      bus.i_rd_req = 1; bus.i_rd_addr = 32'h5000_0000; bus.mem_rd_rdy = 1;
      #1;
      check("t5_fresh_i_rdy", bus.i_rd_rdy, 1);
      check("t5_fresh_no_ret", bus.i_ret_valid, 0);
      tick();
      bus.i_rd_req = 0;
      #1;
      check("t5_fresh_ret", bus.i_ret_valid, 1);
      tick();
      idle_inputs();

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!bus.i_rd_req || acc_i) begin
            bus.i_rd_req  = ($urandom_range(0, 2) == 0);
            bus.i_rd_addr = rand_addr();
            bus.i_rd_type = 3'($urandom_range(0, 7));
         end
         if (!bus.d_rd_req || acc_d) begin
            bus.d_rd_req  = ($urandom_range(0, 2) == 0);
            bus.d_rd_addr = rand_addr();
            bus.d_rd_type = 3'($urandom_range(0, 7));
         end
         if (!bus.d_wr_req || acc_w) begin
            bus.d_wr_req   = ($urandom_range(0, 3) == 0);
            bus.d_wr_addr  = rand_addr();
            bus.d_wr_type  = 3'($urandom_range(0, 7));
            bus.d_wr_wstrb = 4'($urandom_range(0, 15));
            bus.d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
         end
         bus.mem_rd_rdy    = ($urandom_range(0, 1) == 1);
         bus.mem_ret_valid = ($urandom_range(0, 2) != 0);
         bus.mem_ret_last  = ($urandom_range(0, 3) == 0);
         bus.mem_ret_data  = $urandom;
         bus.mem_wr_rdy    = ($urandom_range(0, 3) == 0);
      end
      tick();
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
